// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one owner out of N_REQ, bounded hold.
// Ports: clk, clear (sync reset), req/done in; gnt, gnt_id, busy, timeout out.
module rr_grant_scheduler #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              to_q, to_d;

  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic              rel;
  logic              frc;

  // First requester at or after ptr, wrapping.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_q + ID_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Voluntary release wins over the hold limit.
  assign rel = done || !req[id_q];
  assign frc = !rel && (hold_q == HOLD_W'(MAX_HOLD - 1));

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          id_d    = win;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (rel || frc) begin
          state_d = S_IDLE;
          ptr_d   = id_q + ID_W'(1);
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic, computed for the next cycle and registered.
  always_comb begin
    gnt_d  = '0;
    busy_d = (state_d == S_GRANT);
    to_d   = (state_q == S_GRANT) && frc;
    if (state_d == S_GRANT) begin
      gnt_d[id_d] = 1'b1;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule
